data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, depth of the output-pixel FIFO (power of two, ≥2).
REQ-002 SHALL have parameter DATA_WORDS, default 1024, number of 32-bit words in the data RAM.
REQ-003 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, input, 1, synchronous active-high reset.
REQ-005 SHALL have port address_i, input, 32, CPU data byte address.
REQ-006 SHALL have port data_i, input, 32, CPU store data.
REQ-007 SHALL have port wren_i, input, 1, CPU store strobe; the access is a load when low.
REQ-008 SHALL have port data_o, output, 32, load data back to the CPU.
REQ-009 SHALL have port button_i, input, 1, asynchronous push-button.
REQ-010 SHALL have port LEDs_o, output, 8, LED register.
REQ-011 SHALL have port pix_valid_o, output, 1, the FIFO head is valid.
REQ-012 SHALL have port pix_ready_i, input, 1, the downstream sink accepts the head.
REQ-013 SHALL have port pix_pos_o, output, 16, pixel index (address − 262144).
REQ-014 SHALL have port pix_data_o, output, 8, pixel value.
REQ-015 SHALL have port overflow_o, output, 1, sticky flag indicating a pixel was dropped.

Function
REQ-016 SHALL decode address_i as follows:
- DATA for 0..4095.
- LED at 4096.
- BTN at 4100.
- IMG for addresses ≥ 262144 and < 262144+65536.
- Any other address is UNMAPPED.
REQ-017 DATA region SHALL index its word as address_i[11:2].
REQ-018 A store to DATA SHALL write the word on that edge.
REQ-019 A load SHALL present its result on data_o exactly one cycle after the address (registered, 1-cycle latency).
REQ-020 A load and a store to the same DATA word in one cycle SHALL return the old contents (read-first).
REQ-021 A store to LED SHALL load LEDs_o with data_i[7:0].
REQ-022 A load from LED SHALL return {24'b0, LEDs_o}.
REQ-023 button_i SHALL pass through a 2-flop synchronizer.
REQ-024 A synchronized rising edge SHALL set a sticky `pressed` bit.
REQ-025 A load from BTN SHALL return {30'b0, pressed, sync_level} and clear `pressed`.
REQ-026 If a new edge coincides with that BTN load, `pressed` SHALL remain set.
REQ-027 A store to IMG SHALL push {address_i − 262144 truncated to 16 bits, data_i[7:0]} into the FIFO.
REQ-028 A load from IMG SHALL return 0.
REQ-029 UNMAPPED loads SHALL return 0; UNMAPPED stores SHALL have no effect.
REQ-030 FIFO handshake: a pop occurs when pix_valid_o && pix_ready_i on a rising edge.
REQ-031 pix_pos_o and pix_data_o SHALL be stable while pix_valid_o is high and pix_ready_i is low.
REQ-032 Empty FIFO: pix_valid_o SHALL be low; pix_pos_o and pix_data_o are don't-care.
REQ-033 Full FIFO with an IMG store and no pop in the same cycle: the pixel SHALL be dropped, overflow_o SHALL be set, and FIFO contents SHALL be unchanged.
REQ-034 Full FIFO with an IMG store and a pop in the same cycle: the push SHALL be accepted and the count SHALL remain FIFO_DEPTH.
REQ-035 Empty FIFO with an IMG store: pix_valid_o SHALL rise the next cycle; there is no same-cycle bypass.
REQ-036 Read/write pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL range 0..FIFO_DEPTH.
REQ-037 overflow_o SHALL be cleared only by RST.

Reset
REQ-038 While RST is high on a rising edge, the block SHALL clear: data_o, LEDs_o, pix_valid_o, overflow_o, pressed, both synchronizer flops, FIFO pointers and count.
REQ-039 Reset SHALL NOT clear the DATA RAM contents.
REQ-040 Stores and pops presented while RST is high SHALL be ignored.
REQ-041 On reset asserted mid-drain, FIFO entries SHALL be discarded and pix_valid_o SHALL be low the following cycle.

Structure
REQ-042 Package dmem_pkg SHALL hold:
- constants DATA_LIMIT=4095, LED_ADDR=4096, BTN_ADDR=4100, IMG_BASE=262144, IMG_SIZE=65536;
- a region enum {REG_DATA, REG_LED, REG_BTN, REG_IMG, REG_UNMAPPED};
- a packed pixel struct {pos[15:0], data[7:0]}.
REQ-043 The FIFO SHALL be a separate sub-module pix_fifo (synchronous, parameterized width/depth, with push, pop, full, empty).
REQ-044 The address decoder SHALL be combinational logic inside data_mem_responder.

Verification
REQ-045 Store 0xDEADBEEF to 8, then load 8: data_o = 0xDEADBEEF one cycle after the load; same-cycle store 0x1 and load of 8 returns 0xDEADBEEF.
REQ-046 Store 0xA5 to 4096: LEDs_o = 0xA5 next cycle; load 4096 returns 0x000000A5; store to 5000 leaves LEDs_o and RAM unchanged, and load 5000 returns 0.
REQ-047 Button scenario:
- Stimulus: pulse button_i high for 3 cycles; then, after 3 cycles, load 4100; then load again.
- Response: the first load returns 0x2 or 0x3; the second returns 0x0 or 0x1 (pressed cleared).
REQ-048 Overflow scenario:
- Stimulus: hold pix_ready_i=0; store 9 pixels to 262144+k with data k for k = 0..8.
- Response: 8 entries are held and overflow_o=1.
- Then raise pix_ready_i: 8 pops are observed with pos 0..7 in order, followed by pix_valid_o=0.
REQ-049 Full-FIFO simultaneous push/pop: pix_ready_i=1 with a store in the same cycle leaves the count at 8; no overflow is flagged; the order is preserved.
REQ-050 Mid-drain reset: assert RST with 4 entries queued; next cycle pix_valid_o=0, LEDs_o=0, overflow_o=0, and previously written DATA words still read back.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared address map, region encoding and pixel record for the data-memory responder.
package dmem_pkg;

  localparam logic [31:0] DATA_LIMIT = 32'd4095;
  localparam logic [31:0] LED_ADDR   = 32'd4096;
  localparam logic [31:0] BTN_ADDR   = 32'd4100;
  localparam logic [31:0] IMG_BASE   = 32'd262144;
  localparam logic [31:0] IMG_SIZE   = 32'd65536;

  typedef enum logic [2:0] {
    REG_DATA,
    REG_LED,
    REG_BTN,
    REG_IMG,
    REG_UNMAPPED
  } region_e;

  typedef struct packed {
    logic [15:0] pos;
    logic [7:0]  data;
  } pixel_t;

endpackage

// File: rtl/pix_fifo.sv
// Synchronous FIFO; a push into a full FIFO is accepted only when a pop frees a slot that same edge.
module pix_fifo #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only pointers decide what is valid.
  always_ff @(posedge CLK) begin
    if (!RST && do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/data_mem_responder.sv
// CPU data-bus responder: word RAM, LED register, synchronized button, and an image-pixel FIFO.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_WORDS = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] address_i,
  input  logic [31:0] data_i,
  input  logic        wren_i,
  output logic [31:0] data_o,
  input  logic        button_i,
  output logic [7:0]  LEDs_o,
  output logic        pix_valid_o,
  input  logic        pix_ready_i,
  output logic [15:0] pix_pos_o,
  output logic [7:0]  pix_data_o,
  output logic        overflow_o
);

  localparam logic [15:0] IMG_OFS = IMG_BASE[15:0];

  region_e     region;
  logic [31:0] mem [DATA_WORDS];
  logic [9:0]  word_idx;
  logic        btn_meta_p0;
  logic        btn_sync_p1;
  logic        btn_prev_p2;
  logic        btn_rise;
  logic        pressed;
  logic        btn_load;
  logic        img_push;
  logic        pix_pop;
  logic        fifo_full;
  logic        fifo_empty;
  pixel_t      pix_in;
  pixel_t      pix_head;

  always_comb begin
    region = REG_UNMAPPED;
    if (address_i <= DATA_LIMIT)
      region = REG_DATA;
    else if (address_i == LED_ADDR)
      region = REG_LED;
    else if (address_i == BTN_ADDR)
      region = REG_BTN;
    else if (address_i >= IMG_BASE && address_i < IMG_BASE + IMG_SIZE)
      region = REG_IMG;
  end

  assign word_idx = address_i[11:2];
  assign btn_load = !wren_i && (region == REG_BTN);
  assign btn_rise = btn_sync_p1 && !btn_prev_p2;
  assign img_push = wren_i && (region == REG_IMG);
  assign pix_pop  = pix_valid_o && pix_ready_i;
  assign pix_in   = '{pos: address_i[15:0] - IMG_OFS, data: data_i[7:0]};

  always_ff @(posedge CLK) begin
    if (!RST && wren_i && region == REG_DATA) mem[word_idx] <= data_i;
  end

  // Load path: every cycle reads the current address, so a same-cycle store returns old data.
  always_ff @(posedge CLK) begin
    if (RST) begin
      data_o <= '0;
    end else begin
      case (region)
        REG_DATA: data_o <= mem[word_idx];
        REG_LED:  data_o <= {24'b0, LEDs_o};
        REG_BTN:  data_o <= {30'b0, pressed, btn_sync_p1};
        default:  data_o <= '0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      LEDs_o      <= '0;
      btn_meta_p0 <= 1'b0;
      btn_sync_p1 <= 1'b0;
      btn_prev_p2 <= 1'b0;
      pressed     <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      if (wren_i && region == REG_LED) LEDs_o <= data_i[7:0];
      btn_meta_p0 <= button_i;
      btn_sync_p1 <= btn_meta_p0;
      btn_prev_p2 <= btn_sync_p1;
      // A fresh edge wins over the clear-on-read.
      if (btn_rise)      pressed <= 1'b1;
      else if (btn_load) pressed <= 1'b0;
      if (img_push && fifo_full && !pix_pop) overflow_o <= 1'b1;
    end
  end

  pix_fifo #(
    .DATA_W ($bits(pixel_t)),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (img_push),
    .wdata (pix_in),
    .pop   (pix_pop),
    .rdata (pix_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign pix_valid_o = !fifo_empty;
  assign pix_pos_o   = pix_head.pos;
  assign pix_data_o  = pix_head.data;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: RAM, LED, button, pixel FIFO and reset behaviour.
module tb_data_mem_responder;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] address_i;
  logic [31:0] data_i;
  logic        wren_i;
  logic [31:0] data_o;
  logic        button_i;
  logic [7:0]  LEDs_o;
  logic        pix_valid_o;
  logic        pix_ready_i;
  logic [15:0] pix_pos_o;
  logic [7:0]  pix_data_o;
  logic        overflow_o;

  int total = 0;
  int bad   = 0;

  data_mem_responder #(.FIFO_DEPTH(8), .DATA_WORDS(1024)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .address_i   (address_i),
    .data_i      (data_i),
    .wren_i      (wren_i),
    .data_o      (data_o),
    .button_i    (button_i),
    .LEDs_o      (LEDs_o),
    .pix_valid_o (pix_valid_o),
    .pix_ready_i (pix_ready_i),
    .pix_pos_o   (pix_pos_o),
    .pix_data_o  (pix_data_o),
    .overflow_o  (overflow_o)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic w);
    address_i = a;
    data_i    = d;
    wren_i    = w;
  endtask

  initial begin
    RST = 1'b1; button_i = 1'b0; pix_ready_i = 1'b0;
    bus(32'd5000, 32'd0, 1'b0);
    step(); step();
    RST = 1'b0;
    chk("rst_data_o",   data_o, 32'h0);
    chk("rst_leds",     32'(LEDs_o), 32'h0);
    chk("rst_valid",    32'(pix_valid_o), 32'h0);
    chk("rst_overflow", 32'(overflow_o), 32'h0);

    // RAM store, load, and read-first collision
    bus(32'd8, 32'hDEADBEEF, 1'b1); step();
    bus(32'd8, 32'h0, 1'b0);        step();
    chk("ram_load", data_o, 32'hDEADBEEF);
    bus(32'd8, 32'h1, 1'b1);        step();
    chk("ram_read_first", data_o, 32'hDEADBEEF);
    bus(32'd8, 32'h0, 1'b0);        step();
    chk("ram_new_value", data_o, 32'h1);

    // LED register and unmapped access
    bus(32'd4096, 32'hFFFF_FFA5, 1'b1); step();
    chk("led_store", 32'(LEDs_o), 32'hA5);
    bus(32'd4096, 32'h0, 1'b0);         step();
    chk("led_load", data_o, 32'h0000_00A5);
    bus(32'd5000, 32'h1234_5678, 1'b1); step();
    chk("unmapped_led", 32'(LEDs_o), 32'hA5);
    bus(32'd8, 32'h0, 1'b0);            step();
    chk("unmapped_ram", data_o, 32'h1);
    bus(32'd5000, 32'h0, 1'b0);         step();
    chk("unmapped_load", data_o, 32'h0);

    // Button: 3-cycle pulse, wait, then two loads
    bus(32'd0, 32'h0, 1'b0);
    button_i = 1'b1; step(); step(); step();
    button_i = 1'b0; step(); step(); step();
    bus(32'd4100, 32'h0, 1'b0); step();
    chk("btn_first", data_o, 32'h2);
    step();
    chk("btn_second", data_o, 32'h0);

    // IMG load returns zero and does not enqueue
    bus(32'd262144, 32'h0, 1'b0); step();
    chk("img_load", data_o, 32'h0);
    chk("img_load_nopush", 32'(pix_valid_o), 32'h0);

    // Overflow: 9 stores with the sink stalled
    for (int k = 0; k < 9; k++) begin
      bus(32'd262144 + 32'(k), 32'(k), 1'b1); step();
      if (k == 0) chk("valid_after_first", 32'(pix_valid_o), 32'h1);
    end
    bus(32'd0, 32'h0, 1'b0);
    chk("ovf_set", 32'(overflow_o), 32'h1);
    chk("ovf_head_pos", 32'(pix_pos_o), 32'h0);
    step();
    chk("ovf_head_stable", 32'(pix_pos_o), 32'h0);
    pix_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("drain_valid", 32'(pix_valid_o), 32'h1);
      chk("drain_pos",   32'(pix_pos_o),   32'(k));
      chk("drain_data",  32'(pix_data_o),  32'(k));
      step();
    end
    chk("drain_empty", 32'(pix_valid_o), 32'h0);
    chk("ovf_sticky", 32'(overflow_o), 32'h1);
    pix_ready_i = 1'b0;

    // Full FIFO with simultaneous push and pop
    RST = 1'b1; step(); RST = 1'b0;
    chk("ovf_cleared", 32'(overflow_o), 32'h0);
    for (int k = 16; k < 24; k++) begin
      bus(32'd262144 + 32'(k), 32'(k), 1'b1); step();
    end
    bus(32'd262144 + 32'd24, 32'd24, 1'b1);
    pix_ready_i = 1'b1; step();
    pix_ready_i = 1'b0;
    bus(32'd0, 32'h0, 1'b0);
    chk("pushpop_no_ovf", 32'(overflow_o), 32'h0);
    pix_ready_i = 1'b1;
    for (int k = 17; k < 25; k++) begin
      chk("pushpop_valid", 32'(pix_valid_o), 32'h1);
      chk("pushpop_pos",   32'(pix_pos_o),   32'(k));
      step();
    end
    chk("pushpop_empty", 32'(pix_valid_o), 32'h0);
    pix_ready_i = 1'b0;

    // Reset mid-drain; stores during reset are ignored
    bus(32'd4096, 32'h3C, 1'b1); step();
    for (int k = 0; k < 4; k++) begin
      bus(32'd262144 + 32'(k), 32'(k), 1'b1); step();
    end
    chk("pre_rst_valid", 32'(pix_valid_o), 32'h1);
    pix_ready_i = 1'b1;
    bus(32'd4096, 32'h77, 1'b1);
    RST = 1'b1; step();
    RST = 1'b0; pix_ready_i = 1'b0;
    bus(32'd8, 32'h0, 1'b0);
    chk("mid_rst_valid", 32'(pix_valid_o), 32'h0);
    chk("mid_rst_leds",  32'(LEDs_o), 32'h0);
    chk("mid_rst_ovf",   32'(overflow_o), 32'h0);
    step();
    chk("ram_survives_rst", data_o, 32'h1);
    chk("leds_after_rst", 32'(LEDs_o), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
